serial_det_sched: RTL and testbench
===================================

# serial_det_sched

Round-robin scheduler that shares one serial bit-pattern detector (`din_vld`/`din` in, single-cycle `result` pulse out) between `N_CH` frame sources. It grants one requester at a time, flushes the detector, serializes the granted frame MSB-first into it, and collects the detector's result pulses. Each hit is tagged with the owning channel, and a per-frame hit count is reported. It sits between the frame sources and the detector instance and is the detector's only driver.

## Interface
- `N_CH`, 4: number of requesting channels, 2..8.
- `FRAME_W`, 8: bits per frame, 2..32.
- `DET_LAT`, 2: cycles after the last bit during which detector results are still attributed to the frame, 1..7.
- `HCW`, `$clog2(FRAME_W+DET_LAT+1)`: hit-count width (derived, not overridden).

- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous and active-high.
- `req` in N_CH: per-channel frame-ready request, level.
- `frame` in N_CH*FRAME_W: channel i frame at bits [i*FRAME_W +: FRAME_W]; stable while `req[i]`=1.
- `ack` out N_CH: one-hot, one-cycle pulse; the frame of that channel was captured.
- `det_flush` out 1: one-cycle pulse; the detector clears its history (wired to the detector's reset via inverter).
- `det_din_vld` out 1: bit valid to the detector.
- `det_din` out 1: serial bit to the detector.
- `det_result` in 1: detector hit pulse.
- `hit_vld` out 1: a hit was attributed this cycle.
- `hit_ch` out `$clog2(N_CH)`: channel of that hit.
- `done_vld` out 1: one-cycle pulse at frame end.
- `done_ch` out `$clog2(N_CH)`: channel of the finished frame.
- `done_hits` out HCW: number of hits in the finished frame.

## Operation
- FSM states: IDLE, FLUSH, SHIFT, DRAIN.
- **IDLE, no request:** stays in IDLE while `req`=0.
- **IDLE, request present:** picks the first set `req` bit searching upward (wrapping) from `last+1`.
  - Captures that channel's frame into the shift register and latches `cur_ch`.
  - Pulses `ack[cur_ch]`, sets `last`=`cur_ch`, clears the hit counter, and moves to FLUSH.
- **FLUSH:** `det_flush`=1 for one cycle, then SHIFT.
- **SHIFT:** FRAME_W cycles with `det_din_vld`=1 and `det_din`=shift register MSB; the register shifts left each cycle. After the last bit, moves to DRAIN.
- **DRAIN:** DET_LAT cycles with `det_din_vld`=0 and `det_din`=0. On the last DRAIN cycle it asserts `done_vld` with `done_ch` and `done_hits`, then returns to IDLE.
- **Hit attribution:** `det_result` sampled high in SHIFT or DRAIN increments the counter (saturating at the HCW maximum) and raises `hit_vld`/`hit_ch` one cycle later. `det_result` in IDLE or FLUSH is ignored.
- **Final-cycle hit:** a hit on the final DRAIN cycle is included in `done_hits`. The count and `done_*` outputs use the incremented value combinationally through the registered output.
- **Request handling:** `req` is sampled only in IDLE. Dropping `req` while not granted is legal and never produces an `ack`.
- **Reset value of every output is 0.** Reset also forces IDLE, `last`=N_CH-1 (so ch0 wins first), counter 0, and shift register 0. A reset mid-frame aborts the frame with no `done_vld`.

## Timing
- Frame slot is 2+FRAME_W+DET_LAT cycles from the IDLE grant cycle to the `done_vld` cycle; the next grant is the following cycle.
- Cycle-level sequence, with the grant taken at cycle g:
  - `ack` is registered and high in cycle g+1.
  - `det_flush` is high in g+1.
  - Bits are presented in g+2 … g+1+FRAME_W.
  - `done_vld` is high in g+2+FRAME_W+DET_LAT.
- `hit_vld` latency is 1 cycle from `det_result`.
- `det_*` outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package `serial_det_pkg`: state enum (IDLE/FLUSH/SHIFT/DRAIN) and the width-helper functions reused by the detector's other wrappers.
- One sub-module `rr_pick` (N_CH-wide, combinational round-robin priority picker from `last`). Everything else stays in this module.

## Test plan
- **Stub detector:** `det_result` = registered (`det_din` & `det_din_vld`), i.e. a one-cycle-late bit echo.
- **Single request:** `req`=0001, `frame[7:0]`=8'hB5.
  - `ack`=0001 one cycle.
  - Bits 1,0,1,1,0,1,0,1.
  - Five `hit_vld` pulses with `hit_ch`=0.
  - `done_hits`=5, 12 cycles grant→done.
- **Round-robin, all requesting:** `req`=1111 held.
  - Grants go 0,1,2,3,0.
  - Consecutive `done_vld` exactly 12 cycles apart.
- **Late hit:** frame 8'h01 on ch2.
  - Last bit's hit arrives in DRAIN and is counted: `done_ch`=2, `done_hits`=1.
  - A spurious `det_result` forced in IDLE gives no `hit_vld`.
- **Reset mid-frame:** `rst` asserted in the 4th SHIFT cycle.
  - Next cycle all outputs are 0 and no `done_vld` follows.
  - After release, `req`=1000 is granted and ch3 runs cleanly from FLUSH.
- **Withdrawn request:** `req`=0110 with the pointer at ch1, ch2 drops `req` during ch1's frame.
  - Next grant returns to ch1 (ch2 gets no `ack`).
- **Saturation:** FRAME_W=32, DET_LAT=7, frame all ones, stub detector held high.
  - `done_hits`=39 (HCW=6, no wrap).

Source files
------------

// File: rtl/serial_det_pkg.sv
// serial_det_pkg: shared state encoding and width helpers for the serial detector wrappers
package serial_det_pkg;
  typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, DRAIN} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int bits, input int lat);
    return $clog2(bits + lat + 1);
  endfunction
endpackage

// File: rtl/serial_det_sched_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req searching upward from last+1
module rr_pick
  import serial_det_pkg::*;
#(
  parameter int N = 4,
  localparam int CW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last,
  output logic          vld,
  output logic [CW-1:0] idx
);
  logic [CW-1:0] c;
  always_comb begin
    vld = |req;
    idx = '0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = CW'((int'(last) + k) % N);
      idx = req[c] ? c : idx;
    end
  end
endmodule

// File: rtl/serial_det_sched.sv
// serial_det_sched: round-robin sharing of one serial pattern detector among N_CH frame sources
module serial_det_sched
  import serial_det_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int FRAME_W = 8,
  parameter int DET_LAT = 2,
  localparam int HCW = cnt_w(FRAME_W, DET_LAT),
  localparam int CW = idx_w(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH*FRAME_W-1:0] frame,
  output logic [N_CH-1:0]         ack,
  output logic                    det_flush,
  output logic                    det_din_vld,
  output logic                    det_din,
  input  logic                    det_result,
  output logic                    hit_vld,
  output logic [CW-1:0]           hit_ch,
  output logic                    done_vld,
  output logic [CW-1:0]           done_ch,
  output logic [HCW-1:0]          done_hits
);
  state_t             state_q;
  logic [CW-1:0]      last_q, cur_q, pick;
  logic               pick_vld, counting;
  logic [FRAME_W-1:0] sr_q;
  logic [HCW-1:0]     hits_q, bcnt_q, hits_inc;

  rr_pick #(.N(N_CH)) u_pick (.req(req), .last(last_q), .vld(pick_vld), .idx(pick));

  assign counting = det_result && (state_q == SHIFT || state_q == DRAIN);
  assign hits_inc = &hits_q ? hits_q : hits_q + 1'b1;

  // bcnt_q counts bits in SHIFT and latency cycles in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= CW'(N_CH - 1);
      cur_q <= '0;
      sr_q <= '0;
      hits_q <= '0;
      bcnt_q <= '0;
      ack <= '0;
      det_flush <= 1'b0;
      det_din_vld <= 1'b0;
      det_din <= 1'b0;
      hit_vld <= 1'b0;
      hit_ch <= '0;
      done_vld <= 1'b0;
      done_ch <= '0;
      done_hits <= '0;
    end else begin
      ack <= '0;
      det_flush <= 1'b0;
      hit_vld <= counting;
      done_vld <= 1'b0;
      if (counting) begin
        hits_q <= hits_inc;
        hit_ch <= cur_q;
      end
      case (state_q)
        IDLE: if (pick_vld) begin
          cur_q <= pick;
          last_q <= pick;
          sr_q <= frame[pick*FRAME_W +: FRAME_W];
          ack <= N_CH'(1) << pick;
          hits_q <= '0;
          det_flush <= 1'b1;
          state_q <= FLUSH;
        end
        FLUSH: begin
          det_din_vld <= 1'b1;
          det_din <= sr_q[FRAME_W-1];
          sr_q <= sr_q << 1;
          bcnt_q <= '0;
          state_q <= SHIFT;
        end
        SHIFT: if (bcnt_q == HCW'(FRAME_W - 1)) begin
          det_din_vld <= 1'b0;
          det_din <= 1'b0;
          bcnt_q <= '0;
          state_q <= DRAIN;
        end else begin
          det_din <= sr_q[FRAME_W-1];
          sr_q <= sr_q << 1;
          bcnt_q <= bcnt_q + 1'b1;
        end
        DRAIN: if (bcnt_q == HCW'(DET_LAT - 1)) begin
          done_vld <= 1'b1;
          done_ch <= cur_q;
          done_hits <= counting ? hits_inc : hits_q;
          state_q <= IDLE;
        end else begin
          bcnt_q <= bcnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_det_sched.sv
// tb_serial_det_sched: self-checking bench with a stub echo detector and a frame-level reference model
module tb_serial_det_sched;
  localparam int N = 4, W = 8, L = 2, SLOT = 2 + W + L;

  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0;
  logic [W-1:0] fr [N];
  logic [N*W-1:0] frame;
  logic [N-1:0] ack;
  logic det_flush, det_din_vld, det_din, hit_vld, done_vld;
  logic det_res = 1'b0, force_res = 1'b0;
  logic [1:0] hit_ch, done_ch;
  logic [3:0] done_hits;

  logic [1:0] req2 = '0, ack2;
  logic [63:0] frame2 = '0;
  logic res2 = 1'b0, flush2, vld2, din2, hv2, dv2;
  logic hc2, dc2;
  logic [5:0] dh2;

  int n_chk = 0, n_fail = 0, tcyc = 0;

  always #5 clk = ~clk;
  assign frame = {fr[3], fr[2], fr[1], fr[0]};
  always @(posedge clk) det_res <= force_res | (det_din & det_din_vld);
  always @(posedge clk) tcyc <= tcyc + 1;

  serial_det_sched #(.N_CH(N), .FRAME_W(W), .DET_LAT(L)) dut (
    .clk(clk), .rst(rst), .req(req), .frame(frame), .ack(ack), .det_flush(det_flush),
    .det_din_vld(det_din_vld), .det_din(det_din), .det_result(det_res), .hit_vld(hit_vld),
    .hit_ch(hit_ch), .done_vld(done_vld), .done_ch(done_ch), .done_hits(done_hits));

  serial_det_sched #(.N_CH(2), .FRAME_W(32), .DET_LAT(7)) dut_sat (
    .clk(clk), .rst(rst), .req(req2), .frame(frame2), .ack(ack2), .det_flush(flush2),
    .det_din_vld(vld2), .det_din(din2), .det_result(res2), .hit_vld(hv2),
    .hit_ch(hc2), .done_vld(dv2), .done_ch(dc2), .done_hits(dh2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int l);
    for (int k = 1; k <= N; k++) if (r[(l + k) % N]) return (l + k) % N;
    return -1;
  endfunction

  // Frame-level reference: grant order from the round-robin rule, hits = ones in the frame
  logic [N-1:0] req_s;
  logic [N*W-1:0] frame_s;
  logic rst_s;
  int cyc = 0, m_last = N - 1, m_cur = 0, m_t = 0, m_hc = 0, m_nb = 0;
  bit armed = 0, busy = 0, exp_done;
  logic [W-1:0] m_frame, m_bits;
  logic [N-1:0] exp_ack;
  always begin
    @(posedge clk);
    req_s <= req;
    frame_s <= frame;
    rst_s <= rst;
    #1;
    cyc++;
    if (rst_s) begin
      armed = 1; busy = 0; m_last = N - 1;
      chk("reset_outs", {ack, det_flush, det_din_vld, det_din, hit_vld, hit_ch, done_vld, done_ch, done_hits}, '0);
    end else if (armed) begin
      exp_ack = (!busy && req_s != 0) ? N'(1 << rr(req_s, m_last)) : '0;
      chk("ack", ack, exp_ack);
      chk("flush", det_flush, exp_ack != 0);
      if (exp_ack != 0) begin
        m_cur = rr(req_s, m_last); m_last = m_cur; busy = 1; m_t = cyc;
        m_frame = frame_s[m_cur*W +: W]; m_hc = 0; m_nb = 0; m_bits = '0;
      end else if (busy) begin
        if (det_din_vld) begin m_bits = {m_bits[W-2:0], det_din}; m_nb++; end
        if (hit_vld) begin m_hc++; chk("hit_ch", hit_ch, m_cur); end
      end
      if (!busy) chk("hit_idle", hit_vld, 0);
      exp_done = busy && (cyc - m_t == SLOT - 1);
      chk("done_vld", done_vld, exp_done);
      if (exp_done) begin
        chk("done_ch", done_ch, m_cur);
        chk("done_hits", done_hits, $countones(m_frame));
        chk("hit_pulses", m_hc, $countones(m_frame));
        chk("bits", m_bits, m_frame);
        chk("bit_count", m_nb, W);
        busy = 0;
      end
    end
  end

  task automatic tick(); @(posedge clk); #2; endtask
  task automatic do_reset(); rst = 1; tick(); tick(); rst = 0; endtask

  task automatic wait_ack(output int ch);
    bit ok = 0;
    ch = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (ack != 0) begin
        ok = 1;
        for (int j = 0; j < N; j++) if (ack[j]) ch = j;
      end
    end
    chk("ack_seen", ok, 1);
  endtask

  task automatic wait_done(output int n, output int ch, output int hits);
    bit ok = 0;
    n = 0; ch = -1; hits = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(); n++;
      if (done_vld) begin ok = 1; ch = done_ch; hits = done_hits; end
    end
    chk("done_seen", ok, 1);
  endtask

  typedef struct { int ch; logic [W-1:0] f; int hits; } vec_t;
  vec_t tbl[6];
  int ch, n, dch, dh, cnt, t_prev;
  bit ok;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl = '{'{0, 8'hB5, 5}, '{2, 8'h01, 1}, '{3, 8'hFF, 8},
            '{1, 8'h00, 0}, '{1, 8'h80, 1}, '{2, 8'hAA, 4}};
    for (int i = 0; i < N; i++) fr[i] = '0;
    do_reset();
    foreach (tbl[i]) begin
      fr[tbl[i].ch] = tbl[i].f;
      req = N'(1) << tbl[i].ch;
      wait_ack(ch);
      chk("tbl_ack_ch", ch, tbl[i].ch);
      req = '0;
      tick();
      chk("tbl_ack_pulse", ack, 0);
      wait_done(n, dch, dh);
      chk("tbl_done_ch", dch, tbl[i].ch);
      chk("tbl_hits", dh, tbl[i].hits);
      chk("tbl_latency", n + 1, SLOT - 1);
    end
    // stray detector pulse while idle must not be attributed
    tick(); force_res = 1; tick(); force_res = 0;
    tick(); chk("spurious_hit", hit_vld, 0);
    tick(); chk("spurious_hit2", hit_vld, 0);

    do_reset();
    for (int i = 0; i < N; i++) fr[i] = W'($urandom);
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(ch);
      chk("rr_order", ch, k % N);
      if (k == 4) req = '0;
      wait_done(n, dch, dh);
      if (k > 0) chk("rr_spacing", tcyc - t_prev, SLOT);
      t_prev = tcyc;
    end

    do_reset();
    fr[0] = 8'hC3; req = 4'b0001;
    wait_ack(ch); req = '0;
    repeat (4) tick();
    rst = 1; tick(); rst = 0;
    chk("midrst_outs", {ack, det_flush, det_din_vld, det_din, hit_vld, hit_ch, done_vld, done_ch, done_hits}, '0);
    cnt = 0;
    repeat (20) begin tick(); cnt += done_vld; end
    chk("midrst_no_done", cnt, 0);
    fr[3] = 8'h3C; req = 4'b1000;
    wait_ack(ch);
    chk("midrst_ch3", ch, 3);
    chk("midrst_flush", det_flush, 1);
    req = '0;
    wait_done(n, dch, dh);
    chk("midrst_done_ch", dch, 3);
    chk("midrst_hits", dh, 4);

    do_reset();
    fr[0] = 8'h0F; req = 4'b0001;
    wait_ack(ch); req = '0;
    wait_done(n, dch, dh);
    fr[1] = 8'h5A; fr[2] = 8'h96; req = 4'b0110;
    wait_ack(ch);
    chk("wd_first", ch, 1);
    repeat (3) tick();
    req[2] = 1'b0;
    wait_done(n, dch, dh);
    wait_ack(ch);
    chk("wd_second", ch, 1);
    req = '0;
    wait_done(n, dch, dh);
    chk("wd_done_ch", dch, 1);

    frame2 = {32'h0, 32'hFFFF_FFFF}; res2 = 1; req2 = 2'b01;
    ok = 0; dh = -1;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (ack2 != 0) req2 = '0;
      if (dv2) begin ok = 1; dh = dh2; dch = dc2; end
    end
    chk("sat_done_seen", ok, 1);
    chk("sat_hits", dh, 39);
    chk("sat_ch", dch, 0);
    res2 = 0;

    do_reset();
    for (int c = 0; c < 800; c++) begin
      tick();
      rst = ($urandom_range(299) == 0);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3) == 0) begin fr[i] = W'($urandom); req[i] = 1'b1; end
        else if (req[i] && $urandom_range(15) == 0) req[i] = 1'b0;
      end
    end
    rst = 0; req = '0;
    repeat (30) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
